alu_multiciclo: RTL and testbench
=================================

Name: alu_multiciclo

Overview:
- Parametrised N-bit ALU and the successor to the 1-bit ALU slice.
- Adds a start/done handshake and registered results with flags.
- Single-cycle logic and arithmetic ops complete in one cycle; multiply and shifts run as iterative multi-cycle operations.
- Sits between the register file operand latches and the writeback mux of the monocycle/multicycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted only when busy_o=0.
- op_i  in  4  operation code, latched on acceptance.
- a_i  in  WIDTH  operand A, latched on acceptance.
- b_i  in  WIDTH  operand B, latched on acceptance.
- result_o  out  WIDTH  registered result; holds until next completion.
- zero_o  out  1  result_o==0.
- carry_o  out  1  adder carry-out (ADD/SUB only, else 0).
- overflow_o  out  1  signed overflow (ADD/SUB only, else 0).
- illegal_o  out  1  last completed op_i was unassigned.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE; all outputs and internal operand/accumulator registers = 0. The first start_i after rst_i deasserts is accepted normally.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLT (signed), 0100 XOR, 0101 NOR, 0110 SUB, 0111 SLTU.
  - 1000 MUL: low WIDTH bits of product.
  - 1001 SLL, 1010 SRL, 1011 SRA: shift amount = b_i[SHW-1:0].
  - 1100-1111: illegal.
- SUB = A + ~B + 1, using the invert-B adder. carry_o=1 means no borrow.
- overflow_o = (sA==sB') & (sR!=sA), where B' is the inverted B for SUB.
- SLT/SLTU result = {WIDTH-1 zeros, less}. SLT less = sign of (A-B) XOR overflow. SLTU less = ~carry of A-B.
- FSM states IDLE, MULT, SHIFT, DONE:
  - IDLE: on start_i at edge T, latch op/a/b.
    - Single-cycle or illegal op -> DONE, with result and flags registered at edge T.
    - MUL -> MULT, with cnt=WIDTH and acc=0.
    - Shift with shamt=0 -> DONE, result=A.
    - Shift with shamt>0 -> SHIFT, with cnt=shamt and the working register loaded from A.
  - MULT: each cycle, if mplier[0] then acc+=mcand; then mcand<<=1, mplier>>=1, cnt-=1. At cnt==1 the final iteration writes result_o; next state DONE.
  - SHIFT: one bit per cycle (SRA replicates the MSB); cnt-=1. On the last bit, result_o is written; next state DONE.
  - DONE: done_o=1 for exactly this cycle; next state IDLE.
- Latency from acceptance edge T: single-cycle/illegal op, done_o high in cycle T+1. MUL at T+WIDTH+1. Shift at T+shamt+1.
- start_i while busy_o=1 (including during DONE) is ignored; there is no queueing.
- Flag rules:
  - Flags update only when result_o updates.
  - zero_o is valid for all ops.
  - illegal ops give result 0, zero_o=1, illegal_o=1.
  - MUL/shift ops give carry_o=overflow_o=0.
- Back-to-back throughput: one op per 2 cycles minimum (IDLE->DONE->IDLE).

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND..OP_SRA);
  - the state encoding (IDLE=2'd0, MULT=2'd1, SHIFT=2'd2, DONE=2'd3);
  - a function for the overflow expression.
- One sub-module, alu_nbit_comb: the combinational WIDTH-bit datapath for opcodes 0000-0111. It takes a, b and op and produces result, carry, overflow. The top level instantiates it for single-cycle ops.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001 -> at T+1: result 0x80000000, overflow_o=1, carry_o=0, zero_o=0, done_o one cycle.
- SUB a=5 b=5 -> result 0, zero_o=1, carry_o=1. SLT a=0xFFFFFFFF b=1 -> 1. SLTU with the same operands -> 0.
- MUL a=0x00010001 b=0x0000FFFF -> result 0xFFFFFFFF; done_o exactly at T+33; busy_o high for T+1..T+33.
- SRA a=0x80000000 b=4 -> 0xF8000000 at T+5. SRL with the same operands -> 0x08000000. SLL b=0x20 (shamt 0) -> a unchanged at T+1.
- Start MUL, assert start_i with op ADD at T+3 -> ignored, MUL result unaffected. op 1101 -> result 0, illegal_o=1, done at T+1.
- Start MUL, pulse rst_i mid-cycle at T+10 -> outputs immediately 0, busy_o=0. An ADD 2+3 issued after release -> 5 at T'+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU:
// opcodes, FSM state encoding and the overflow helper.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed overflow: operands agree in sign, result does not.
  function automatic logic ovf_calc(
    input logic sa,
    input logic sb,
    input logic sr
  );
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_nbit_comb.sv
// Combinational WIDTH-bit datapath for the single-cycle
// logic, add/sub and set-less-than operations.
module alu_nbit_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             inv_b;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             ovf_raw;
  logic             less_s;
  logic             less_u;

  // SUB and both compares share the invert-B adder path.
  assign inv_b = (op == OP_SUB) || (op == OP_SLT) ||
                 (op == OP_SLTU);
  assign bx    = inv_b ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, bx} +
                 {{WIDTH{1'b0}}, inv_b};

  assign ovf_raw = ovf_calc(a[WIDTH-1], bx[WIDTH-1],
                            sum[WIDTH-1]);
  assign less_s  = sum[WIDTH-1] ^ ovf_raw;
  assign less_u  = ~sum[WIDTH];

  // Result select; carry/overflow exposed only for ADD/SUB.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_ADD, OP_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = ovf_raw;
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, less_s};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, less_u};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multiciclo.sv
// N-bit ALU with start/done handshake; MUL and shifts
// iterate one step per cycle, everything else is one cycle.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             illegal_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] work;
  logic [SHW:0]     cnt;

  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_ovf;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH-1:0] shift_next;
  logic             last;

  alu_nbit_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a        (a_i),
    .b        (b_i),
    .op       (op_i),
    .result   (c_res),
    .carry    (c_carry),
    .overflow (c_ovf)
  );

  assign shamt    = b_i[SHW-1:0];
  assign mul_next = acc + (mplier[0] ? mcand : '0);
  assign last     = (cnt == {{SHW{1'b0}}, 1'b1});
  assign busy_o   = (state != IDLE);

  // One-bit step of the latched shift operation.
  always_comb begin
    shift_next = work;
    case (op_q)
      OP_SLL:  shift_next = work << 1;
      OP_SRL:  shift_next = work >> 1;
      default: shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  // Control FSM with registered result, flags and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      op_q       <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      work       <= '0;
      cnt        <= '0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      illegal_o  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            mcand  <= a_i;
            mplier <= b_i;
            work   <= a_i;
            acc    <= '0;
            if (!op_i[3]) begin
              result_o   <= c_res;
              zero_o     <= (c_res == '0);
              carry_o    <= c_carry;
              overflow_o <= c_ovf;
              illegal_o  <= 1'b0;
              done_o     <= 1'b1;
              state      <= DONE;
            end else if (op_i == OP_MUL) begin
              cnt   <= (SHW+1)'(WIDTH);
              state <= MULT;
            end else if (op_i[3:2] == 2'b11) begin
              result_o   <= '0;
              zero_o     <= 1'b1;
              carry_o    <= 1'b0;
              overflow_o <= 1'b0;
              illegal_o  <= 1'b1;
              done_o     <= 1'b1;
              state      <= DONE;
            end else if (shamt == '0) begin
              result_o   <= a_i;
              zero_o     <= (a_i == '0);
              carry_o    <= 1'b0;
              overflow_o <= 1'b0;
              illegal_o  <= 1'b0;
              done_o     <= 1'b1;
              state      <= DONE;
            end else begin
              cnt   <= {1'b0, shamt};
              state <= SHIFT;
            end
          end
        end
        MULT: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (last) begin
            result_o   <= mul_next;
            zero_o     <= (mul_next == '0);
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            illegal_o  <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end
        end
        SHIFT: begin
          work <= shift_next;
          cnt  <= cnt - 1'b1;
          if (last) begin
            result_o   <= shift_next;
            zero_o     <= (shift_next == '0);
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
            illegal_o  <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: driver pushes model
// results, a negedge monitor pops them on each done pulse.
module tb_alu_multiciclo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         ovf;
  logic         ill;
  logic         busy;
  logic         done;

  alu_multiciclo #(
    .WIDTH (W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .result_o   (result),
    .zero_o     (zero),
    .carry_o    (carry),
    .overflow_o (ovf),
    .illegal_o  (ill),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          cyc;
    logic [3:0]  op;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on whole words.
  // cyc holds the extra cycles beyond a single-cycle op.
  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t        e;
    logic [32:0] s33;
    longint      sl;
    logic signed [31:0] sx;
    logic        c;
    logic        v;
    logic        il;
    int          sh;
    c  = 1'b0;
    v  = 1'b0;
    il = 1'b0;
    sh = int'(y[4:0]);
    e.cyc = 0;
    e.op  = o;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: begin
        s33   = {1'b0, x} + {1'b0, y};
        e.res = s33[31:0];
        c     = s33[32];
        sl    = longint'($signed(x)) + longint'($signed(y));
        v     = (sl > 64'sd2147483647) ||
                (sl < -64'sd2147483648);
      end
      4'd3: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4: e.res = x ^ y;
      4'd5: e.res = ~(x | y);
      4'd6: begin
        e.res = x - y;
        c     = (x >= y);
        sl    = longint'($signed(x)) - longint'($signed(y));
        v     = (sl > 64'sd2147483647) ||
                (sl < -64'sd2147483648);
      end
      4'd7: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd8: begin
        e.res = x * y;
        e.cyc = W;
      end
      4'd9: begin
        e.res = x << sh;
        e.cyc = sh;
      end
      4'd10: begin
        e.res = x >> sh;
        e.cyc = sh;
      end
      4'd11: begin
        sx    = x;
        sx    = sx >>> sh;
        e.res = sx;
        e.cyc = sh;
      end
      default: begin
        e.res = 32'd0;
        il    = 1'b1;
      end
    endcase
    e.fl = {(e.res == 32'd0), c, v, il};
    return e;
  endfunction

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w == 100) chk("busy_timeout", {31'b0, busy}, 32'd0);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    e     = model(o, x, y);
    e.cyc = e.cyc + cyc;
    q.push_back(e);
    start = 1'b0;
  endtask

  // Monitor: compare every completion with the queue head.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_pulse_width", {31'b0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        me = q.pop_front();
        chk($sformatf("result op%0d", me.op), result, me.res);
        chk($sformatf("flags zcvi op%0d", me.op),
            {28'b0, zero, carry, ovf, ill}, {28'b0, me.fl});
        chk($sformatf("latency op%0d", me.op), cyc, me.cyc);
      end
    end
    prev_done = done;
  end

  initial begin
    int w;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'b0, zero, carry, ovf, ill}, 32'd0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1000, 32'h0001_0001, 32'h0000_FFFF);
    repeat (16) @(negedge clk);
    chk("mul_busy", {30'b0, busy, done}, 32'd2);
    issue(4'b1011, 32'h8000_0000, 32'd4);
    issue(4'b1010, 32'h8000_0000, 32'd4);
    issue(4'b1001, 32'h1234_5678, 32'h0000_0020);
    issue(4'b1101, 32'hDEAD_BEEF, 32'h1);

    // ADD request while MUL is busy must be dropped.
    issue(4'b1000, 32'h0000_1234, 32'h0000_0101);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 4'b0010;
    a     = 32'd1;
    b     = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset in the middle of a multiply.
    issue(4'b0010, 32'd7, 32'd8);
    issue(4'b1000, 32'h0000_0003, 32'h0000_0007);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy_done", {30'b0, busy, done}, 32'd0);
    chk("midrst_flags", {28'b0, zero, carry, ovf, ill}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(4'b0010, 32'd2, 32'd3);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      y = $urandom;
      x = ($urandom_range(0, 5) == 0) ? y : $urandom;
      issue(4'($urandom_range(0, 15)), x, y);
    end

    w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue", q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
